// File: rtl/seq_tx_pkg.sv
// Shared types and default constants for the serial test-pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned PAT_W_DEF    = 8;
  localparam int unsigned TICK_DIV_DEF = 100_000_000;
  localparam int unsigned LEN_W_DEF    = 5;

endpackage

// File: rtl/seq_tx_tick.sv
// Free-running auto-advance divider: one-cycle tick_c when the count reaches TICK_DIV-1.
module seq_tx_tick
  import seq_tx_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial test-pattern transmitter: sends a latched pattern MSB-first, one bit per advance.
// Optional SEQ_TX_LOOP_EN adds a stop input and continuous pattern repetition.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned PAT_W    = PAT_W_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             auto,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
`ifdef SEQ_TX_LOOP_EN
  ,
  input  logic             stop
`endif
);

  state_e state, state_d;

  logic [PAT_W-1:0] sreg, sreg_d;
  logic [LEN_W-1:0] len_q, len_d, bit_idx_d;
  logic             bit_out_d, bit_valid_d, busy_d, done_d;
`ifdef SEQ_TX_LOOP_EN
  logic [PAT_W-1:0] pat_q, pat_d;
`endif

  logic [LEN_W-1:0] eff_len_c;
  logic [PAT_W-1:0] aligned_c;
  logic             last_c, tick_c, advance_c, tick_clr_c;

  // Out-of-range lengths fall back to the full pattern; the pattern is left-justified so the MSB is sent first.
  assign eff_len_c  = (len == '0 || len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign aligned_c  = pattern << (LEN_W'(PAT_W) - eff_len_c);
  assign last_c     = (bit_idx == len_q - LEN_W'(1));
  assign advance_c  = auto ? tick_c : step;
  assign tick_clr_c = !auto || (state != SEND);

  seq_tx_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr_c),
    .en    (state == SEND),
    .tick_c(tick_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      len_q     <= '0;
      bit_idx   <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TX_LOOP_EN
      pat_q     <= '0;
`endif
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      len_q     <= len_d;
      bit_idx   <= bit_idx_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef SEQ_TX_LOOP_EN
      pat_q     <= pat_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    sreg_d      = sreg;
    len_d       = len_q;
    bit_idx_d   = bit_idx;
    bit_out_d   = bit_out;
    bit_valid_d = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
`ifdef SEQ_TX_LOOP_EN
    pat_d       = pat_q;
`endif
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = SEND;
          sreg_d      = aligned_c;
          len_d       = eff_len_c;
          bit_idx_d   = '0;
          bit_out_d   = aligned_c[PAT_W-1];
          bit_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifdef SEQ_TX_LOOP_EN
          pat_d       = aligned_c;
`endif
        end
      end
      SEND: begin
        busy_d = 1'b1;
`ifdef SEQ_TX_LOOP_EN
        if (stop) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (advance_c) begin
          bit_valid_d = 1'b1;
          if (!last_c) begin
            sreg_d    = sreg << 1;
            bit_out_d = sreg[PAT_W-2];
            bit_idx_d = bit_idx + LEN_W'(1);
          end else begin
            sreg_d    = pat_q;
            bit_out_d = pat_q[PAT_W-1];
            bit_idx_d = '0;
          end
        end
`else
        if (advance_c) begin
          if (!last_c) begin
            sreg_d      = sreg << 1;
            bit_out_d   = sreg[PAT_W-2];
            bit_idx_d   = bit_idx + LEN_W'(1);
            bit_valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: vector table plus directed reset/loop sequences.
// Builds with or without SEQ_TX_LOOP_EN.
module tb_seq_pattern_tx;

  localparam int unsigned PAT_W    = 8;
  localparam int unsigned TICK_DIV = 5;
  localparam int unsigned LEN_W    = 5;
  localparam int          GAP      = 10;

  typedef struct {
    logic [7:0]  pattern;
    logic [4:0]  len;
    logic        auto_m;
    int          n;
    logic [15:0] bits;  // bit i = i-th bit on the wire
  } vec_t;

  typedef struct {
    logic       b;
    logic [4:0] idx;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       auto_mode = 1'b0;
  logic [7:0] pattern = '0;
  logic [4:0] len = '0;
`ifdef SEQ_TX_LOOP_EN
  logic       stop = 1'b0;
`endif
  logic       bit_out, bit_valid, busy, done;
  logic [4:0] bit_idx;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   strobes = 0;
  logic last_bit = 1'b0;

  exp_t sb_q[$];
  int   done_q[$];
  vec_t vecs[6];

  seq_pattern_tx #(
    .PAT_W   (PAT_W),
    .TICK_DIV(TICK_DIV),
    .LEN_W   (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .auto     (auto_mode),
    .pattern  (pattern),
    .len      (len),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx)
`ifdef SEQ_TX_LOOP_EN
    ,
    .stop     (stop)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every strobe and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid) begin
        strobes++;
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("strobe_bit", int'(bit_out), int'(e.b));
          check("strobe_idx", int'(bit_idx), int'(e.idx));
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_busy", int'(busy), 1);
        end
        last_bit <= bit_out;
      end else if (busy) begin
        check("bit_hold", int'(bit_out), int'(last_bit));
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
          check("done_busy", int'(busy), 0);
          check("done_bit_hold", int'(bit_out), int'(last_bit));
        end
      end
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_strobe(input logic b, input int idx, input int at);
    exp_t e;
    e.b   = b;
    e.idx = 5'(idx);
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input logic first_bit);
    start = 1'b1;
    push_strobe(first_bit, 0, cyc + 1);
    tick_wait(1);
    start = 1'b0;
  endtask

  // Waits GAP-1 cycles (with a stray start mid-gap), then one step; last=1 ends the send.
  task automatic manual_step(input logic b, input int idx, input bit last);
    for (int g = 1; g < GAP; g++) begin
      start = (g == 3);
      tick_wait(1);
    end
    start = 1'b0;
    step  = 1'b1;
    if (!last) begin
      push_strobe(b, idx, cyc + 1);
    end else begin
      done_q.push_back(cyc + 1);
`ifdef SEQ_TX_LOOP_EN
      stop = 1'b1;
`endif
    end
    tick_wait(1);
    step = 1'b0;
`ifdef SEQ_TX_LOOP_EN
    stop = 1'b0;
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int c;
    pattern   = v.pattern;
    len       = v.len;
    auto_mode = v.auto_m;
    c = cyc;
    do_start(v.bits[0]);
    if (!v.auto_m) begin
      for (int i = 1; i <= v.n; i++) manual_step(v.bits[i], i, i == v.n);
    end else begin
      for (int i = 1; i < v.n; i++) push_strobe(v.bits[i], i, c + 1 + int'(TICK_DIV) * i);
      done_q.push_back(c + 1 + int'(TICK_DIV) * v.n);
      for (int k = 1; k <= int'(TICK_DIV) * v.n + 1; k++) begin
        start = (k == 7);
        step  = (k == 12 || k == 13);
`ifdef SEQ_TX_LOOP_EN
        stop  = (k == int'(TICK_DIV) * v.n);
`endif
        tick_wait(1);
      end
      start = 1'b0;
      step  = 1'b0;
`ifdef SEQ_TX_LOOP_EN
      stop  = 1'b0;
`endif
    end
    tick_wait(3);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(bit_valid), 0);
  endtask

  initial begin
    int seen;

    vecs[0] = '{pattern: 8'h0D, len: 5'd4,  auto_m: 1'b0, n: 4, bits: 16'h000B};
    vecs[1] = '{pattern: 8'hA5, len: 5'd0,  auto_m: 1'b1, n: 8, bits: 16'h00A5};
    vecs[2] = '{pattern: 8'hC1, len: 5'd20, auto_m: 1'b0, n: 8, bits: 16'h0083};
    vecs[3] = '{pattern: 8'h01, len: 5'd1,  auto_m: 1'b0, n: 1, bits: 16'h0001};
    vecs[4] = '{pattern: 8'hFA, len: 5'd3,  auto_m: 1'b1, n: 3, bits: 16'h0002};
    vecs[5] = '{pattern: 8'h6E, len: 5'd8,  auto_m: 1'b0, n: 8, bits: 16'h0076};

    tick_wait(2);
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bit_idx", int'(bit_idx), 0);
    rst_n = 1'b1;
    tick_wait(2);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset between bit 2 and bit 3 of an A5 transmission.
    pattern   = 8'hA5;
    len       = 5'd0;
    auto_mode = 1'b0;
    do_start(1'b1);
    manual_step(1'b0, 1, 1'b0);
    manual_step(1'b1, 2, 1'b0);
    tick_wait(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_bit_out", int'(bit_out), 0);
    check("async_bit_valid", int'(bit_valid), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_bit_idx", int'(bit_idx), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = strobes;
    repeat (3) begin
      step = 1'b1;
      tick_wait(1);
      step = 1'b0;
      tick_wait(3);
    end
    check("no_strobe_after_reset", strobes, seen);
    check("idle_after_reset", int'(busy), 0);

`ifdef SEQ_TX_LOOP_EN
    // Looping 3-bit pattern; final stop shares its cycle with a step.
    pattern   = 8'b0000_0101;
    len       = 5'd3;
    auto_mode = 1'b0;
    do_start(1'b1);
    manual_step(1'b0, 1, 1'b0);
    manual_step(1'b1, 2, 1'b0);
    manual_step(1'b1, 0, 1'b0);
    manual_step(1'b0, 1, 1'b0);
    manual_step(1'b1, 2, 1'b0);
    manual_step(1'b1, 0, 1'b0);
    manual_step(1'b0, 0, 1'b1);
    tick_wait(3);
    check("loop_idle_busy", int'(busy), 0);
`endif

    tick_wait(2);
    check("scoreboard_empty", sb_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
